// File: rtl/class_mem_banked.sv
// Banked class-hypervector store: streams elements round-robin into N_BANKS RAMs, reads one row per address.
// Optional CLASS_MEM_ACC_EN adds acc_mode for saturating read-modify-write accumulation during load.
module class_mem_banked #(
   parameter int DIV_SIZE   = 512,
   parameter int FTWIDTH    = 8,
   parameter int N_BANKS    = 16,
   parameter int ADDR_WIDTH = 11,
   parameter int CLASS_W    = 5
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         load_start,
   input  logic [CLASS_W-1:0]           class_num,
`ifdef CLASS_MEM_ACC_EN
   input  logic                         acc_mode,
`endif
   input  logic                         in_valid,
   input  logic [FTWIDTH-1:0]           in_data,
   output logic                         in_ready,
   output logic                         write_done,
   output logic                         overflow,
   input  logic                         rd_en,
   input  logic [ADDR_WIDTH-1:0]        rd_addr,
   output logic                         rd_valid,
   output logic [N_BANKS*FTWIDTH-1:0]   rd_data
);

   localparam int BANK_W = $clog2(N_BANKS);
   localparam int K_W    = ADDR_WIDTH + BANK_W;
   localparam int T_W    = K_W + 1;
   localparam int DEPTH  = 1 << ADDR_WIDTH;
   localparam logic [63:0] CAPACITY = 64'(N_BANKS) << ADDR_WIDTH;
   localparam logic [FTWIDTH-1:0] SAT_MAX = {1'b0, {(FTWIDTH-1){1'b1}}};
   localparam logic [FTWIDTH-1:0] SAT_MIN = {1'b1, {(FTWIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t                        state_reg;
   logic [K_W-1:0]                k_reg;
   logic [T_W-1:0]                target_reg;
   logic                          in_ready_reg;
   logic                          write_done_reg;
   logic                          overflow_reg;
   logic                          rd_valid_reg;
   logic [N_BANKS*FTWIDTH-1:0]    rd_hold_reg;
   logic                          phase_reg;
   logic [FTWIDTH-1:0]            acc_data_reg;
   logic                          acc_sel;

   logic [63:0]                   req_total;
   logic                          req_over;
   logic [T_W-1:0]                req_target;
   logic                          load_active;
   logic                          transfer;
   logic                          step;
   logic                          last_k;
   logic                          rd_fire;
   logic [BANK_W-1:0]             bank_sel;
   logic [ADDR_WIDTH-1:0]         mem_addr;
   logic [N_BANKS*FTWIDTH-1:0]    bank_rows;

   // Requested size is formed at 64 bits so a large class_num can never wrap below capacity.
   assign req_total  = 64'(DIV_SIZE) * 64'(class_num);
   assign req_over   = (req_total > CAPACITY);
   assign req_target = req_over ? T_W'(CAPACITY) : T_W'(req_total);

   assign load_active = (state_reg == LOAD);
   assign in_ready    = in_ready_reg & ~load_start;
   assign transfer    = in_valid & in_ready;
   assign step        = acc_sel ? (phase_reg & ~load_start) : transfer;
   assign last_k      = ({1'b0, k_reg} == (target_reg - T_W'(1)));
   assign rd_fire     = rd_en & ~load_active;
   assign bank_sel    = k_reg[BANK_W-1:0];
   assign mem_addr    = load_active ? k_reg[K_W-1:BANK_W] : rd_addr;

   assign write_done  = write_done_reg;
   assign overflow    = overflow_reg;
   assign rd_valid    = rd_valid_reg;
   assign rd_data     = rd_valid_reg ? bank_rows : rd_hold_reg;

`ifdef CLASS_MEM_ACC_EN
   logic acc_reg;

   always_ff @(posedge clk) begin
      if (reset)
         acc_reg <= 1'b0;
      else if (load_start)
         acc_reg <= acc_mode;
   end

   assign acc_sel = acc_reg;
`else
   assign acc_sel = 1'b0;
`endif

   generate
      for (genvar gi = 0; gi < N_BANKS; gi++) begin : g_bank
         logic [FTWIDTH-1:0]        mem [DEPTH];
         logic [FTWIDTH-1:0]        q_reg;
         logic signed [FTWIDTH:0]   sum;
         logic [FTWIDTH-1:0]        sat;
         logic [FTWIDTH-1:0]        wdata;
         logic                      sel;
         logic                      we;
         logic                      re;

         // Sign-extended add; a carry disagreeing with the sign bit means the result left the range.
         assign sum   = $signed({q_reg[FTWIDTH-1], q_reg}) + $signed({acc_data_reg[FTWIDTH-1], acc_data_reg});
         assign sat   = (sum[FTWIDTH] != sum[FTWIDTH-1]) ? (sum[FTWIDTH] ? SAT_MIN : SAT_MAX)
                                                         : sum[FTWIDTH-1:0];
         assign wdata = acc_sel ? sat : in_data;
         assign sel   = (bank_sel == BANK_W'(gi));
         assign we    = load_active & sel & (acc_sel ? (phase_reg & ~load_start) : transfer);
         assign re    = rd_fire | (load_active & sel & acc_sel & transfer);

         always_ff @(posedge clk) begin
            if (we)
               mem[mem_addr] <= wdata;
            if (re)
               q_reg <= mem[mem_addr];
         end

         assign bank_rows[gi*FTWIDTH +: FTWIDTH] = q_reg;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         k_reg          <= '0;
         target_reg     <= '0;
         in_ready_reg   <= 1'b0;
         write_done_reg <= 1'b0;
         overflow_reg   <= 1'b0;
         rd_valid_reg   <= 1'b0;
         rd_hold_reg    <= '0;
         phase_reg      <= 1'b0;
         acc_data_reg   <= '0;
      end else begin
         rd_valid_reg <= rd_fire;
         if (rd_valid_reg)
            rd_hold_reg <= bank_rows;

         if (load_start) begin
            k_reg          <= '0;
            phase_reg      <= 1'b0;
            target_reg     <= req_target;
            overflow_reg   <= req_over;
            write_done_reg <= (req_target == '0);
            in_ready_reg   <= (req_target != '0);
            state_reg      <= (req_target == '0) ? DONE : LOAD;
         end else if (load_active) begin
            if (acc_sel && transfer) begin
               // First half of an accumulate: RAM read issued, write lands next cycle.
               phase_reg    <= 1'b1;
               acc_data_reg <= in_data;
               in_ready_reg <= 1'b0;
            end else if (step) begin
               phase_reg <= 1'b0;
               if (last_k) begin
                  state_reg      <= DONE;
                  write_done_reg <= 1'b1;
                  in_ready_reg   <= 1'b0;
               end else begin
                  k_reg        <= k_reg + K_W'(1);
                  in_ready_reg <= 1'b1;
               end
            end
         end
      end
   end

endmodule
